// File: rtl/pixel_coord_gen_pkg.sv
// rtl/pixel_coord_gen_pkg.sv - shared geometry defaults and frame-tracking state encoding
package pixel_coord_gen_pkg;

    localparam int H_ACTIVE_DEF = 1024;
    localparam int V_ACTIVE_DEF = 768;
    localparam int COORD_W_DEF  = 11;
    localparam int RGB565_W     = 16;

    typedef enum logic [1:0] {
        SYNC_WAIT  = 2'd0,
        FRAME_IDLE = 2'd1,
        LINE       = 2'd2
    } pcg_state_t;

    function automatic logic in_window(input int x, input int y, input int h, input int v);
        return (x < h) && (y < v);
    endfunction

endpackage

// File: rtl/pixel_coord_gen.sv
// rtl/pixel_coord_gen.sv - pixel coordinate tagging and frame geometry tracking for the camera stream
module pixel_coord_gen
    import pixel_coord_gen_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int COORD_W  = COORD_W_DEF,
    parameter int DATA_W   = RGB565_W
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic               vsync_in,
    input  logic               de_in,
    input  logic               pixel_valid_in,
    input  logic [DATA_W-1:0]  pixel_in,
    output logic [DATA_W-1:0]  pixel_out,
    output logic               pixel_valid_out,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               frame_start,
    output logic               frame_done,
    output logic [COORD_W-1:0] frame_w_meas,
    output logic [COORD_W-1:0] frame_h_meas,
    output logic               geom_err
);

    localparam logic [COORD_W-1:0] CNT_MAX = {COORD_W{1'b1}};
    localparam logic [COORD_W-1:0] H_CMP   = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_CMP   = COORD_W'(V_ACTIVE);

    pcg_state_t         state, state_nxt;
    logic               vsync_d, de_d;
    logic               vs_rise, de_rise, de_fall;
    logic [COORD_W-1:0] x_cnt, y_cnt, x_pos;
    logic               line_start, line_end, frame_close, px_take, px_emit;

    assign vs_rise = vsync_in & ~vsync_d;
    assign de_rise = de_in & ~de_d;
    assign de_fall = ~de_in & de_d;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    // vsync always wins over line activity on the same cycle
    always_comb begin
        state_nxt   = state;
        line_start  = 1'b0;
        line_end    = 1'b0;
        frame_close = 1'b0;
        px_take     = 1'b0;
        case (state)
            SYNC_WAIT: begin
                if (vs_rise) begin
                    state_nxt = FRAME_IDLE;
                end
            end
            FRAME_IDLE: begin
                if (vs_rise) begin
                    frame_close = 1'b1;
                end else if (de_rise) begin
                    line_start = 1'b1;
                    px_take    = pixel_valid_in;
                    state_nxt  = LINE;
                end
            end
            LINE: begin
                if (vs_rise) begin
                    frame_close = 1'b1;
                    state_nxt   = FRAME_IDLE;
                end else if (de_fall) begin
                    line_end  = 1'b1;
                    state_nxt = FRAME_IDLE;
                end else begin
                    px_take = pixel_valid_in & de_in;
                end
            end
            default: begin
                state_nxt = SYNC_WAIT;
            end
        endcase
        x_pos   = line_start ? '0 : x_cnt;
        px_emit = px_take && in_window(int'(x_pos), int'(y_cnt), H_ACTIVE, V_ACTIVE);
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d         <= 1'b0;
            de_d            <= 1'b0;
            x_cnt           <= '0;
            y_cnt           <= '0;
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
            pixel_x         <= '0;
            pixel_y         <= '0;
            frame_start     <= 1'b0;
            frame_done      <= 1'b0;
            frame_w_meas    <= '0;
            frame_h_meas    <= '0;
            geom_err        <= 1'b0;
        end else begin
            vsync_d         <= vsync_in;
            de_d            <= de_in;
            pixel_valid_out <= px_emit;
            frame_start     <= px_emit && (x_pos == '0) && (y_cnt == '0);
            frame_done      <= frame_close;
            geom_err        <= geom_err
                             | (frame_close && (y_cnt != V_CMP))
                             | (line_end && (x_cnt != H_CMP));
            if (px_emit) begin
                pixel_out <= pixel_in;
                pixel_x   <= x_pos;
                pixel_y   <= y_cnt;
            end
            // counters keep running past the active window so measurements see the true size
            if (frame_close) begin
                frame_h_meas <= y_cnt;
                x_cnt        <= '0;
                y_cnt        <= '0;
            end else if (line_start) begin
                x_cnt <= px_take ? COORD_W'(1) : '0;
            end else if (line_end) begin
                frame_w_meas <= x_cnt;
                y_cnt        <= (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 1'b1;
            end else if (px_take) begin
                x_cnt <= (x_cnt == CNT_MAX) ? x_cnt : x_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// tb/tb_pixel_coord_gen.sv - scoreboard bench for pixel_coord_gen on a reduced geometry
module tb_pixel_coord_gen;
    import pixel_coord_gen_pkg::*;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int CW = 11;
    localparam int DW = 16;

    logic          pixel_clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vsync_in = 1'b0;
    logic          de_in = 1'b0;
    logic          pixel_valid_in = 1'b0;
    logic [DW-1:0] pixel_in = '0;
    logic [DW-1:0] pixel_out;
    logic          pixel_valid_out;
    logic [CW-1:0] pixel_x, pixel_y;
    logic          frame_start, frame_done;
    logic [CW-1:0] frame_w_meas, frame_h_meas;
    logic          geom_err;

    typedef struct {
        int x;
        int y;
        int pix;
        int start;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;

    pixel_coord_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW), .DATA_W(DW)) dut (
        .pixel_clk       (pixel_clk),
        .rst_n           (rst_n),
        .vsync_in        (vsync_in),
        .de_in           (de_in),
        .pixel_valid_in  (pixel_valid_in),
        .pixel_in        (pixel_in),
        .pixel_out       (pixel_out),
        .pixel_valid_out (pixel_valid_out),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .frame_w_meas    (frame_w_meas),
        .frame_h_meas    (frame_h_meas),
        .geom_err        (geom_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    always @(negedge pixel_clk) begin
        if (frame_done) done_cnt++;
        if (frame_start && !pixel_valid_out) check_eq("start_without_valid", 1, 0);
        if (pixel_valid_out) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_pixel", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("px_x", 32'(pixel_x), mon_e.x);
                check_eq("px_y", 32'(pixel_y), mon_e.y);
                check_eq("px_data", 32'(pixel_out), mon_e.pix);
                check_eq("px_start", 32'(frame_start), mon_e.start);
            end
        end
    end

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic strobe(input int x, input int y, input bit expect_px);
        pixel_in       = DW'($urandom);
        pixel_valid_in = 1'b1;
        if (expect_px) sb.push_back('{x, y, int'(pixel_in), (x == 0 && y == 0) ? 1 : 0});
        tick();
        pixel_valid_in = 1'b0;
        tick();
    endtask

    task automatic send_line(input int nstr, input int y, input bit in_frame);
        de_in = 1'b1;
        tick();
        for (int i = 0; i < nstr; i++) strobe(i, y, in_frame && (i < H) && (y < V));
        de_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic vsync_pulse();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_valid", 32'(pixel_valid_out), 0);
        check_eq("rst_x", 32'(pixel_x), 0);
        check_eq("rst_y", 32'(pixel_y), 0);
        check_eq("rst_pix", 32'(pixel_out), 0);
        check_eq("rst_start", 32'(frame_start), 0);
        check_eq("rst_done", 32'(frame_done), 0);
        check_eq("rst_w", 32'(frame_w_meas), 0);
        check_eq("rst_h", 32'(frame_h_meas), 0);
        check_eq("rst_err", 32'(geom_err), 0);
        rst_n = 1'b1;
        tick();

        // strobes before any vsync are discarded
        send_line(4, 0, 1'b0);
        check_eq("t1_no_done", done_cnt, 0);

        // nominal frame
        vsync_pulse();
        check_eq("t2_no_done_first_vsync", done_cnt, 0);
        for (int y = 0; y < V; y++) send_line(H, y, 1'b1);
        check_eq("t2_all_emitted", sb.size(), 0);
        vsync_pulse();
        check_eq("t2_done", done_cnt, 1);
        check_eq("t2_w", 32'(frame_w_meas), H);
        check_eq("t2_h", 32'(frame_h_meas), V);
        check_eq("t2_err", 32'(geom_err), 0);

        // overlong line
        send_line(H + 6, 0, 1'b1);
        check_eq("t3_w", 32'(frame_w_meas), H + 6);
        check_eq("t3_err", 32'(geom_err), 1);

        // short frame
        for (int y = 1; y < 5; y++) send_line(H, y, 1'b1);
        vsync_pulse();
        check_eq("t4_done", done_cnt, 2);
        check_eq("t4_h", 32'(frame_h_meas), 5);
        check_eq("t4_err", 32'(geom_err), 1);

        // vsync collides with a strobe mid-line
        send_line(H, 0, 1'b1);
        de_in = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) strobe(i, 1, 1'b1);
        vsync_in       = 1'b1;
        pixel_valid_in = 1'b1;
        pixel_in       = DW'($urandom);
        tick();
        vsync_in       = 1'b0;
        pixel_valid_in = 1'b0;
        tick();
        de_in = 1'b0;
        tick();
        tick();
        check_eq("t5_done", done_cnt, 3);
        check_eq("t5_h", 32'(frame_h_meas), 1);
        check_eq("t5_dropped", sb.size(), 0);
        send_line(H, 0, 1'b1);
        check_eq("t5_w", 32'(frame_w_meas), H);

        // reset mid-line
        de_in = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) strobe(i, 1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 32'(pixel_valid_out), 0);
        check_eq("t6_x", 32'(pixel_x), 0);
        check_eq("t6_y", 32'(pixel_y), 0);
        check_eq("t6_w", 32'(frame_w_meas), 0);
        check_eq("t6_h", 32'(frame_h_meas), 0);
        check_eq("t6_err", 32'(geom_err), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 10; i < 14; i++) strobe(i, 1, 1'b0);
        de_in = 1'b0;
        tick();
        tick();
        send_line(H, 0, 1'b0);
        vsync_pulse();
        check_eq("t6_no_done_after_reset", done_cnt, 3);
        send_line(H, 0, 1'b1);
        check_eq("t6_w_after", 32'(frame_w_meas), H);
        check_eq("t6_err_after", 32'(geom_err), 0);
        tick();
        check_eq("final_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
